// File: rtl/mem_copy_engine.sv
// Block copy initiator for a single-port memory with combinational read data.
// Moves LENGTH words from src to dst in ascending order, one word per two cycles.
//
// state | meaning
// IDLE  | waiting for start; busy low
// READ  | addr = source pointer; read data captured at the edge
// WRITE | addr = destination pointer; write strobe high with the captured word
// DONE  | one-cycle completion pulse; busy still high
module mem_copy_engine #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 36
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_copied,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  write_enable,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] src_ptr;
    logic [ADDR_WIDTH-1:0] dst_ptr;
    logic [ADDR_WIDTH:0]   remaining;

    // write_data doubles as the data latch: it is loaded in READ and held through WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            src_ptr      <= '0;
            dst_ptr      <= '0;
            remaining    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            words_copied <= '0;
            addr         <= '0;
            write_enable <= 1'b0;
            write_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    write_enable <= 1'b0;
                    done         <= 1'b0;
                    if (start) begin
                        src_ptr      <= src_addr;
                        dst_ptr      <= dst_addr;
                        remaining    <= length;
                        words_copied <= '0;
                        busy         <= 1'b1;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                            addr  <= src_addr;
                        end
                    end
                end
                READ: begin
                    write_data   <= read_data;
                    addr         <= dst_ptr;
                    write_enable <= 1'b1;
                    state        <= WRITE;
                end
                WRITE: begin
                    write_enable <= 1'b0;
                    src_ptr      <= src_ptr + ADDR_WIDTH'(1);
                    dst_ptr      <= dst_ptr + ADDR_WIDTH'(1);
                    remaining    <= remaining - (ADDR_WIDTH + 1)'(1);
                    words_copied <= words_copied + (ADDR_WIDTH + 1)'(1);
                    if (remaining == (ADDR_WIDTH + 1)'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= READ;
                        addr  <= src_ptr + ADDR_WIDTH'(1);
                    end
                end
                DONE: begin
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    write_enable <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    write_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator for the 36-bit x 4096-word unified memory.
- Drives the memory's address, write-enable and write-data inputs; consumes its combinational read data.
- On a start request, copies a block of LENGTH words from a source address to a destination address, one word per two cycles, in ascending address order.
- Used for program/data relocation and buffer moves without processor involvement.

Parameters:
- ADDR_WIDTH, 12, memory address width; address space is 2^ADDR_WIDTH words.
- DATA_WIDTH, 36, memory word width.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  first source word address; latched on accepted start.
- dst_addr  in  ADDR_WIDTH  first destination word address; latched on accepted start.
- length  in  ADDR_WIDTH+1  word count, 0..4096; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle pulse when the block is complete.
- words_copied  out  ADDR_WIDTH+1  count of completed writes in the current/last transfer.
- addr  out  ADDR_WIDTH  memory address.
- write_enable  out  1  memory write strobe.
- write_data  out  DATA_WIDTH  memory write data.
- read_data  in  DATA_WIDTH  memory read data, combinational from addr.

Behaviour:
- Reset (async, active-high):
  - State is IDLE.
  - busy=0, done=0, write_enable=0, addr=0, write_data=0, words_copied=0.
  - Internal source/destination pointers, remaining count and data latch are cleared.
- Outputs are registered. addr, write_enable and write_data are driven from registered state only.
- Memory behaviour: read_data is valid in the same cycle that addr is presented. Writes commit on the rising edge while write_enable=1.
- State machine:
  - IDLE:
    - busy=0, write_enable=0.
    - start=1: latch src, dst and length; clear words_copied.
    - If length=0, go to DONE; otherwise go to READ.
  - READ:
    - addr=src_ptr, write_enable=0.
    - At the clock edge, capture read_data into the data latch, then go to WRITE.
  - WRITE:
    - addr=dst_ptr, write_enable=1, write_data=latched word.
    - At the edge: src_ptr+1, dst_ptr+1, remaining-1, words_copied+1.
    - If remaining was 1, go to DONE; otherwise go to READ.
  - DONE:
    - done=1 for exactly one cycle, busy=1, write_enable=0; then go to IDLE.
- Throughput and latency:
  - 2 cycles per word.
  - For N>0, done asserts 2N+1 cycles after the start edge. For N=0, it asserts 1 cycle after.
- Address arithmetic is modulo 2^ADDR_WIDTH: pointer 4095+1 wraps to 0, with no error.
- length=4096 copies the entire memory.
- Overlap:
  - Copy is strictly forward (ascending).
  - If dst lies inside (src, src+length), already-written words are re-read. This is the defined behaviour and is not corrected.
  - src==dst rewrites the same values.
- start is ignored while not in IDLE; input changes during a transfer have no effect.
- start and done in the same cycle: DONE does not sample start. A start held high is accepted in the following IDLE cycle.
- Reset mid-transfer:
  - Immediate return to IDLE with all outputs at reset values.
  - A write in progress is not committed if reset is asserted before the edge.
  - Words already written stay in memory.
- write_enable is never high outside WRITE. Exactly `length` write strobes occur per transfer.

Test Plan:
- Preload mem[16..19]=0x000000001..0x000000004; start src=16 dst=100 length=4 -> mem[100..103] equal those values; done pulses once at cycle 9 after start; words_copied=4; exactly 4 write_enable cycles.
- length=0, src=5 dst=6 -> no write_enable; done pulses 1 cycle after start; mem[6] unchanged; words_copied=0.
- Wrap: src=4094 dst=10 length=4, mem[4094]=0xA, mem[4095]=0xB, mem[0]=0xC, mem[1]=0xD -> mem[10..13]=A,B,C,D; addr sequence shows 4095 followed by 0.
- Overlap: mem[0..3]=1,2,3,4; src=0 dst=1 length=3 -> mem[0..3]=1,1,1,1. Then src=1 dst=0 length=3 on mem 1,2,3,4 -> 2,3,4,4.
- start re-pulsed with different args mid-transfer -> ignored; original transfer completes unchanged; busy stays high throughout.
- Assert reset asynchronously after 3 of 8 words copied -> outputs return to reset values without waiting for a clock edge; only 3 destination words modified; a subsequent start runs normally.
